// File: rtl/alu_pkg.sv
// Shared op codes, FSM encoding and op classification for alu_mc.
// is_multicycle() includes DIVU/REMU only when ALU_DIV_EN is defined.
package alu_pkg;

  typedef logic [4:0] op_t;

  localparam op_t OP_ADD  = 5'b00000;
  localparam op_t OP_ADC  = 5'b00001;
  localparam op_t OP_SUB  = 5'b00010;
  localparam op_t OP_SBC  = 5'b00011;
  localparam op_t OP_AND  = 5'b00100;
  localparam op_t OP_OR   = 5'b00101;
  localparam op_t OP_XOR  = 5'b00110;
  localparam op_t OP_NOT  = 5'b00111;
  localparam op_t OP_LSL  = 5'b01000;
  localparam op_t OP_LSR  = 5'b01001;
  localparam op_t OP_ASR  = 5'b01010;
  localparam op_t OP_ROL  = 5'b01011;
  localparam op_t OP_ROR  = 5'b01100;
  localparam op_t OP_CTL_FIRST = 5'b01101;
  localparam op_t OP_CTL_LAST  = 5'b10010;
  localparam op_t OP_MUL  = 5'b11000;
  localparam op_t OP_MULH = 5'b11001;
  localparam op_t OP_DIVU = 5'b11010;
  localparam op_t OP_REMU = 5'b11011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  function automatic logic is_multicycle(input op_t op);
`ifdef ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIVU) || (op == OP_REMU);
`else
    return (op == OP_MUL) || (op == OP_MULH);
`endif
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between the read stage, alu_mc and writeback.
// master drives operands and out_ready; slave (the ALU) drives results and in_ready.
interface alu_mc_if #(parameter int WIDTH = 16);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [4:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             z;
  logic             n;
  logic             c;
  logic             v;
  logic             err;

  modport master (
    output flush, in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, y, z, n, c, v, err
  );

  modport slave (
    input  flush, in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, y, z, n, c, v, err
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider (divider only with ALU_DIV_EN), one bit per cycle.
// Latency WIDTH cycles after i_start; o_y/o_c/o_v are valid combinationally while o_done is high.
module alu_muldiv_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_start,
  input  logic [1:0]       i_sel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_y,
  output logic             o_c,
  output logic             o_v
);
  import alu_pkg::*;

  localparam int CW = $clog2(WIDTH);

  logic               r_busy;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic               r_hi;

  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH:0]     w_msum;
  logic [2*WIDTH-1:0] w_mnxt;
  logic [2*WIDTH-1:0] w_nxt;
  logic               w_mflag;

  assign w_hi   = r_acc[2*WIDTH-1:WIDTH];
  assign w_lo   = r_acc[WIDTH-1:0];
  // Multiplier in the low half retires from bit 0 while the product grows into the high half.
  assign w_msum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : '0);
  assign w_mnxt = {w_msum, w_lo[WIDTH-1:1]};

  assign o_done  = r_busy && (r_cnt == CW'(WIDTH - 1));
  assign o_y     = r_hi ? w_nxt[2*WIDTH-1:WIDTH] : w_nxt[WIDTH-1:0];
  assign w_mflag = !r_hi && (w_nxt[2*WIDTH-1:WIDTH] != '0);

`ifdef ALU_DIV_EN
  logic             r_div;
  logic             r_dz;
  logic [WIDTH:0]   w_t;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [2*WIDTH-1:0] w_dnxt;

  // Partial remainder lives in the high half, quotient bits shift into the low half.
  assign w_t    = {w_hi, w_lo[WIDTH-1]};
  assign w_ge   = w_t >= {1'b0, r_b};
  assign w_diff = w_t[WIDTH-1:0] - r_b;
  assign w_dnxt = {(w_ge ? w_diff : w_t[WIDTH-1:0]), w_lo[WIDTH-2:0], w_ge};

  assign w_nxt = r_div ? w_dnxt : w_mnxt;
  assign o_c   = r_div ? 1'b0 : w_mflag;
  assign o_v   = r_div ? r_dz : w_mflag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= 1'b0;
      r_dz  <= 1'b0;
    end else if (i_start && !i_flush) begin
      r_div <= i_sel[1];
      r_dz  <= (i_b == '0);
    end
  end
`else
  logic w_unused_sel;

  assign w_unused_sel = i_sel[1];
  assign w_nxt = w_mnxt;
  assign o_c   = w_mflag;
  assign o_v   = w_mflag;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_b    <= '0;
      r_hi   <= 1'b0;
    end else if (i_flush) begin
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_acc  <= {{WIDTH{1'b0}}, i_a};
      r_b    <= i_b;
      r_hi   <= i_sel[0];
    end else if (r_busy) begin
      r_acc <= w_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multicycle handshaked ALU: 1-cycle ops, WIDTH+1-cycle MUL/MULH (and DIVU/REMU with ALU_DIV_EN).
// One op in flight; result, flags and err hold until out_ready; flush aborts any state.
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mc_if.slave  bus
);
  import alu_pkg::*;

  logic [1:0]        r_state;
  logic [WIDTH-1:0]  r_y;
  flags_t            r_flags;
  logic              r_err;

  logic              w_accept;
  logic              w_start;
  logic              w_capture;
  logic              w_sub;
  logic              w_cin;
  logic [WIDTH-1:0]  w_bop;
  logic [WIDTH:0]    w_sum;
  logic [SHW-1:0]    w_s;
  logic [WIDTH:0]    w_lsl;
  logic [WIDTH:0]    w_lsr;
  logic signed [WIDTH:0] w_asr;
  logic [WIDTH-1:0]  w_rol;
  logic [WIDTH-1:0]  w_ror;
  logic [WIDTH-1:0]  w_sc_y;
  logic              w_sc_c;
  logic              w_sc_v;
  logic              w_sc_err;
  logic              w_md_done;
  logic [WIDTH-1:0]  w_md_y;
  logic              w_md_c;
  logic              w_md_v;
  logic [WIDTH-1:0]  w_cap_y;
  logic              w_cap_c;
  logic              w_cap_v;
  logic              w_cap_err;

  assign bus.in_ready  = (r_state == ST_IDLE) && !bus.flush;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.y   = r_y;
  assign bus.z   = r_flags.z;
  assign bus.n   = r_flags.n;
  assign bus.c   = r_flags.c;
  assign bus.v   = r_flags.v;
  assign bus.err = r_err;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_start  = w_accept && is_multicycle(bus.op);

  assign w_sub = (bus.op == OP_SUB) || (bus.op == OP_SBC);
  assign w_cin = ((bus.op == OP_ADC) || (bus.op == OP_SBC)) ? bus.cin : w_sub;
  assign w_bop = w_sub ? ~bus.b : bus.b;
  assign w_sum = {1'b0, bus.a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};

  // Extra guard bit on each shifter catches the last bit shifted out; s=0 leaves it 0.
  assign w_s   = bus.b[SHW-1:0];
  assign w_lsl = {1'b0, bus.a} << w_s;
  assign w_lsr = {bus.a, 1'b0} >> w_s;
  assign w_asr = $signed({bus.a, 1'b0}) >>> w_s;
  assign w_rol = (bus.a << w_s) | (bus.a >> (WIDTH - int'(w_s)));
  assign w_ror = (bus.a >> w_s) | (bus.a << (WIDTH - int'(w_s)));

  always_comb begin
    w_sc_y   = '0;
    w_sc_c   = 1'b0;
    w_sc_v   = 1'b0;
    w_sc_err = 1'b0;
    case (bus.op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        w_sc_y = w_sum[WIDTH-1:0];
        w_sc_c = w_sum[WIDTH];
        w_sc_v = (bus.a[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: w_sc_y = bus.a & bus.b;
      OP_OR:  w_sc_y = bus.a | bus.b;
      OP_XOR: w_sc_y = bus.a ^ bus.b;
      OP_NOT: w_sc_y = ~bus.a;
      OP_LSL: begin
        w_sc_y = w_lsl[WIDTH-1:0];
        w_sc_c = w_lsl[WIDTH];
      end
      OP_LSR: begin
        w_sc_y = w_lsr[WIDTH:1];
        w_sc_c = w_lsr[0];
      end
      OP_ASR: begin
        w_sc_y = w_asr[WIDTH:1];
        w_sc_c = w_asr[0];
      end
      OP_ROL: begin
        w_sc_y = w_rol;
        w_sc_c = (w_s != '0) && w_rol[0];
      end
      OP_ROR: begin
        w_sc_y = w_ror;
        w_sc_c = (w_s != '0) && w_ror[WIDTH-1];
      end
      default: w_sc_err = 1'b1;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (bus.flush),
    .i_start (w_start),
    .i_sel   (bus.op[1:0]),
    .i_a     (bus.a),
    .i_b     (bus.b),
    .o_done  (w_md_done),
    .o_y     (w_md_y),
    .o_c     (w_md_c),
    .o_v     (w_md_v)
  );

  assign w_capture = (w_accept && !w_start) || ((r_state == ST_BUSY) && w_md_done);
  assign w_cap_y   = (r_state == ST_BUSY) ? w_md_y : w_sc_y;
  assign w_cap_c   = (r_state == ST_BUSY) ? w_md_c : w_sc_c;
  assign w_cap_v   = (r_state == ST_BUSY) ? w_md_v : w_sc_v;
  assign w_cap_err = (r_state == ST_BUSY) ? 1'b0   : w_sc_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_y     <= '0;
      r_flags <= '0;
      r_err   <= 1'b0;
    end else if (bus.flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept)      r_state <= w_start ? ST_BUSY : ST_DONE;
        ST_BUSY: if (w_md_done)     r_state <= ST_DONE;
        ST_DONE: if (bus.out_ready) r_state <= ST_IDLE;
        default:                    r_state <= ST_IDLE;
      endcase
      if (w_capture) begin
        r_y       <= w_cap_y;
        r_flags.z <= (w_cap_y == '0);
        r_flags.n <= w_cap_y[WIDTH-1];
        r_flags.c <= w_cap_c;
        r_flags.v <= w_cap_v;
        r_err     <= w_cap_err;
      end
    end
  end

endmodule
